// File: rtl/seq_pkg.sv
// Shared types for the layer sequencer: FSM states and default-width index/count types.
package seq_pkg;

    localparam int NUM_STAGES_DEF = 4;
    localparam int CNT_WIDTH_DEF  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ERROR = 2'd2
    } state_t;

    typedef logic [$clog2(NUM_STAGES_DEF)-1:0] stage_t;
    typedef logic [CNT_WIDTH_DEF-1:0]          cnt_t;

endpackage

// File: rtl/stage_timer.sv
// Per-stage cycle counter: cleared on stage launch, counts up and saturates at the
// watchdog limit, flags expiry when the limit is reached.
module stage_timer
    import seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 expired
);

    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);

    logic [CNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_q != LIMIT) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign expired = (count_q == LIMIT);

endmodule

// File: rtl/layer_sequencer.sv
// Launches each layer engine in order, waits for its done pulse, records per-stage
// cycle counts and raises a sticky watchdog error if a stage never finishes.
module layer_sequencer
    import seq_pkg::*;
#(
    parameter int NUM_STAGES     = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    output logic                          busy,
    output logic [NUM_STAGES-1:0]         stage_start,
    input  logic [NUM_STAGES-1:0]         stage_done,
    output logic [NUM_STAGES-1:0]         stage_active,
    output logic                          done,
    output logic                          error,
    output logic [$clog2(NUM_STAGES)-1:0] err_stage,
    input  logic                          clear_err,
    input  logic [$clog2(NUM_STAGES)-1:0] perf_sel,
    output logic [CNT_WIDTH-1:0]          perf_cycles
);

    localparam int SW = $clog2(NUM_STAGES);
    localparam logic [SW-1:0]         LAST = SW'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0] ONE  = NUM_STAGES'(1);

    state_t                               state_q, state_d;
    logic [SW-1:0]                        cur_q, cur_d;
    logic                                 busy_q, busy_d;
    logic [NUM_STAGES-1:0]                stage_start_q, stage_start_d;
    logic [NUM_STAGES-1:0]                stage_active_q, stage_active_d;
    logic                                 done_q, done_d;
    logic                                 error_q, error_d;
    logic [SW-1:0]                        err_stage_q, err_stage_d;
    logic [NUM_STAGES-1:0][CNT_WIDTH-1:0] perf_q, perf_d;
    logic [CNT_WIDTH-1:0]                 perf_cycles_q, perf_cycles_d;

    logic                 launch;
    logic                 perf_we;
    logic [CNT_WIDTH-1:0] timer_count;
    logic                 timer_expired;

    // Timer restarts on the same edge that launches a stage, so it reads 0 while
    // stage_start is high.
    stage_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (launch),
        .count   (timer_count),
        .expired (timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        launch      = 1'b0;
        perf_we     = 1'b0;
        done_d      = 1'b0;
        error_d     = error_q;
        err_stage_d = err_stage_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cur_d   = '0;
                    launch  = 1'b1;
                end
            end
            RUN: begin
                // A done pulse in the expiry cycle still counts as success.
                if (stage_done[cur_q]) begin
                    perf_we = 1'b1;
                    if (cur_q == LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cur_d  = cur_q + 1'b1;
                        launch = 1'b1;
                    end
                end else if (timer_expired) begin
                    state_d     = ERROR;
                    error_d     = 1'b1;
                    err_stage_d = cur_q;
                end
            end
            ERROR: begin
                if (clear_err) begin
                    state_d     = IDLE;
                    error_d     = 1'b0;
                    err_stage_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d         = (state_d == RUN);
        stage_start_d  = launch ? (ONE << cur_d) : '0;
        stage_active_d = (state_d == RUN) ? (ONE << cur_d) : '0;
    end

    always_comb begin
        perf_d = perf_q;
        if (perf_we) begin
            perf_d[cur_q] = timer_count;
        end
        perf_cycles_d = '0;
        if (int'(perf_sel) < NUM_STAGES) begin
            perf_cycles_d = perf_q[perf_sel];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_q          <= '0;
            busy_q         <= 1'b0;
            stage_start_q  <= '0;
            stage_active_q <= '0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            err_stage_q    <= '0;
            perf_q         <= '0;
            perf_cycles_q  <= '0;
        end else begin
            cur_q          <= cur_d;
            busy_q         <= busy_d;
            stage_start_q  <= stage_start_d;
            stage_active_q <= stage_active_d;
            done_q         <= done_d;
            error_q        <= error_d;
            err_stage_q    <= err_stage_d;
            perf_q         <= perf_d;
            perf_cycles_q  <= perf_cycles_d;
        end
    end

    assign busy         = busy_q;
    assign stage_start  = stage_start_q;
    assign stage_active = stage_active_q;
    assign done         = done_q;
    assign error        = error_q;
    assign err_stage    = err_stage_q;
    assign perf_cycles  = perf_cycles_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Randomized bench: frames are planned as per-stage latencies, expected outputs are laid
// out on an absolute cycle timeline, then the timeline is played against the sequencer.
module tb_layer_sequencer;

    localparam int NS = 3;
    localparam int TO = 20;
    localparam int CW = 32;
    localparam int N  = 4096;

    logic          clk = 1'b0;
    logic          reset, start, clear_err;
    logic          busy, done, error;
    logic [NS-1:0] stage_start, stage_done, stage_active;
    logic [1:0]    err_stage, perf_sel;
    logic [CW-1:0] perf_cycles;

    always #5 clk = ~clk;

    layer_sequencer #(
        .NUM_STAGES     (NS),
        .TIMEOUT_CYCLES (TO),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .busy         (busy),
        .stage_start  (stage_start),
        .stage_done   (stage_done),
        .stage_active (stage_active),
        .done         (done),
        .error        (error),
        .err_stage    (err_stage),
        .clear_err    (clear_err),
        .perf_sel     (perf_sel),
        .perf_cycles  (perf_cycles)
    );

    int vectors = 0;
    int errors  = 0;
    int t;

    // Input plan per cycle
    bit            d_start[N], d_clr[N], d_rst[N];
    logic [NS-1:0] d_done[N];
    // Expected {busy, stage_start[2:0], stage_active[2:0], done, error, err_stage[1:0]}
    logic [10:0]   exp_ctl[N];
    int            mode[N];     // 0 idle, 1 running, 2 error
    int            cur_at[N];
    int            pw_stage[N], pw_val[N];
    bit            pclr[N];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mark_run(input int c, input int i);
        exp_ctl[c][10]  = 1'b1;
        exp_ctl[c][6:4] = 3'(1 << i);
        mode[c]         = 1;
        cur_at[c]       = i;
    endtask

    // lat < 0: stage never answers. rst_off >= 0: reset that many cycles into stage 1.
    task automatic plan_frame(input int l0, input int l1, input int l2,
                              input int rst_off, input bit b2b);
        int lat[3];
        int s, d, e, cc, gap;
        lat = '{l0, l1, l2};
        gap = $urandom_range(1, 4);
        d_start[t] = 1'b1;
        s = t + 1;
        for (int i = 0; i < NS; i++) begin
            exp_ctl[s][9:7] = 3'(1 << i);
            if (rst_off >= 0 && i == 1) begin
                for (int c = s; c <= s + rst_off; c++) mark_run(c, i);
                d_rst[s + rst_off]    = 1'b1;
                pclr[s + rst_off + 1] = 1'b1;
                t = s + rst_off + 1 + gap;
                return;
            end
            if (lat[i] < 0) begin
                e = s + TO;
                for (int c = s; c <= e; c++) mark_run(c, i);
                cc = e + 1 + $urandom_range(0, 5);
                for (int c = e + 1; c <= cc; c++) begin
                    exp_ctl[c][2]   = 1'b1;
                    exp_ctl[c][1:0] = 2'(i);
                    mode[c]         = 2;
                end
                d_clr[cc] = 1'b1;
                t = cc + 1 + gap;
                return;
            end
            d = s + lat[i];
            for (int c = s; c <= d; c++) mark_run(c, i);
            d_done[d][i]   = 1'b1;
            pw_stage[d + 1] = i;
            pw_val[d + 1]   = lat[i];
            s = d + 1;
        end
        exp_ctl[s][3] = 1'b1;
        t = b2b ? s : s + gap;
    endtask

    initial begin
        int            perf_m[NS];
        logic [CW-1:0] exp_pc;
        int            sel, l0, l1, l2, ro;

        for (int c = 0; c < N; c++) begin
            d_done[c]   = '0;
            exp_ctl[c]  = '0;
            mode[c]     = 0;
            cur_at[c]   = 0;
            pw_stage[c] = -1;
            pw_val[c]   = 0;
        end
        t = 2;

        plan_frame(5, 6, 7, -1, 0);     // reference run: starts at +1,+7,+14, done at +22
        plan_frame(5, -1, 0, -1, 0);    // stage 1 hangs
        plan_frame(3, 4, 5, -1, 0);
        plan_frame(TO, 3, 4, -1, 0);    // done lands on the expiry cycle
        plan_frame(-1, 0, 0, -1, 0);    // stage 0 hangs
        plan_frame(4, 9, 2, 3, 0);      // reset during stage 1
        plan_frame(2, 2, 2, -1, 1);     // back-to-back
        plan_frame(0, 0, 0, -1, 1);     // done coincident with launch
        plan_frame(1, TO, -1, -1, 0);   // final stage hangs
        for (int f = 0; f < 16; f++) begin
            l0 = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TO));
            l1 = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TO));
            l2 = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TO));
            ro = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 6)) : -1;
            plan_frame(l0, l1, l2, ro, 1'($urandom_range(0, 1)));
        end

        // Inputs the sequencer must ignore in the state they arrive in
        for (int c = 0; c <= t; c++) begin
            case (mode[c])
                1: begin
                    if ($urandom_range(0, 5) == 0) d_start[c] = 1'b1;
                    if ($urandom_range(0, 5) == 0) d_clr[c]   = 1'b1;
                    if ($urandom_range(0, 2) == 0)
                        d_done[c] = d_done[c] | (3'($urandom) & ~(3'(1) << cur_at[c]));
                end
                2: if ($urandom_range(0, 3) == 0) d_start[c] = 1'b1;
                default: if (!d_start[c] && $urandom_range(0, 7) == 0) d_clr[c] = 1'b1;
            endcase
        end

        reset      = 1'b1;
        start      = 1'b0;
        clear_err  = 1'b0;
        stage_done = '0;
        perf_sel   = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) perf_m[i] = 0;
        exp_pc = '0;

        for (int c = 0; c <= t + 5; c++) begin
            if (pclr[c]) for (int i = 0; i < NS; i++) perf_m[i] = 0;
            if (pw_stage[c] >= 0) perf_m[pw_stage[c]] = pw_val[c];

            chk($sformatf("ctl@%0d", c),
                {busy, stage_start, stage_active, done, error, err_stage}, exp_ctl[c]);
            chk($sformatf("perf@%0d", c), perf_cycles, exp_pc);

            start      = d_start[c];
            clear_err  = d_clr[c];
            stage_done = d_done[c];
            reset      = d_rst[c];
            sel        = $urandom_range(0, NS - 1);
            perf_sel   = 2'(sel);
            exp_pc     = d_rst[c] ? '0 : CW'(perf_m[sel]);
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Top-level inference scheduler for the CNN pipeline. It launches each layer engine (conv, relu, maxpool, dense, …) in fixed order with a one-cycle start pulse. It waits for each engine's one-cycle done pulse and records per-stage cycle counts for profiling. A watchdog flags a stage that never reports done.

## Interface
Parameters:
- NUM_STAGES, 4, number of layer engines sequenced, stage 0 first; ≥2
- TIMEOUT_CYCLES, 1_000_000, max cycles a stage may run before error
- CNT_WIDTH, 32, width of per-stage cycle counters; must hold TIMEOUT_CYCLES

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse: input frame loaded, begin inference
- busy  out  1  high from cycle after accepted start until done/error
- stage_start  out  NUM_STAGES  one-hot one-cycle pulse launching stage i
- stage_done  in  NUM_STAGES  one-cycle done pulse from stage i
- stage_active  out  NUM_STAGES  one-hot level: stage currently running
- done  out  1  one-cycle pulse: final stage completed
- error  out  1  level: watchdog expired; sticky until clear_err or reset
- err_stage  out  $clog2(NUM_STAGES)  index of stage that timed out
- clear_err  in  1  pulse: clear error, return to IDLE
- perf_sel  in  $clog2(NUM_STAGES)  selects stage cycle count to read
- perf_cycles  out  CNT_WIDTH  registered count of selected stage, last run

## Operation
- States: IDLE, RUN, ERROR. cur = current stage index, timer = cycle counter.
- IDLE: start=1 → cur=0, timer=0, RUN; stage_start[0] pulses next cycle.
- RUN, stage_done[cur]=1:
  - perf[cur] ← timer.
  - cur≠NUM_STAGES-1 → cur+1, timer=0, stage_start[cur+1] pulses next cycle.
  - cur=last → IDLE, done pulses next cycle.
- RUN, no done, timer==TIMEOUT_CYCLES → ERROR; error=1, err_stage=cur; no further stage_start.
- Otherwise in RUN, timer increments by 1 per cycle, saturating at TIMEOUT_CYCLES.
- ERROR: holds until clear_err=1 → IDLE, error=0, err_stage=0. start ignored in ERROR.
- start in RUN or ERROR: ignored (no queueing).
- stage_done bits for stages ≠ cur: ignored, no state change.
- stage_done[cur] and timeout in the same cycle: done wins, no error.
- stage_done[cur] in the same cycle stage_start[cur] is high: accepted, perf[cur]=0.
- clear_err outside ERROR: no effect.
- perf registers retain values across runs; overwritten only when that stage completes.
- perf registers are not cleared by a timeout.

## Timing
- All outputs registered.
- Reset values: busy=0, stage_start=0, stage_active=0, done=0, error=0, err_stage=0, perf_cycles=0, all perf registers=0, state=IDLE.
- Reset mid-RUN aborts immediately. The bench must also reset downstream engines.
- start accepted at cycle T → busy=1 and stage_start[0]=1 at T+1. stage_active[0] rises at T+1.
- Let S be the cycle stage_start[i] is high.
- timer=0 at S, timer=k at S+k.
- stage_done[i] sampled at cycle D → perf[i]=D−S.
- Non-final stage: stage_start[i+1] at D+1, stage_active moves at D+1.
- Final stage: done=1, busy=0, stage_active=0 at D+1.
- Back-to-back: new start may be accepted at D+1 (state already IDLE).
- No done by S+TIMEOUT_CYCLES → error=1 and busy=0 at S+TIMEOUT_CYCLES+1.
- perf_cycles = perf[perf_sel] with one-cycle latency.
- perf_cycles updates the cycle after the perf register is written.

## Structure
- Package seq_pkg: state_t enum {IDLE, RUN, ERROR}.
- seq_pkg also holds stage index typedef stage_t and cnt_t (CNT_WIDTH).
- Sub-module stage_timer: clear, increment, saturation and timeout compare.
  - Input: clear. Outputs: count, expired.
- Sequencer FSM and perf register file remain in layer_sequencer.

## Test plan
Bench parameters: NUM_STAGES=3, TIMEOUT_CYCLES=20.
- Normal run: start at T=0. Each stage i answers stage_done 5+i cycles after its stage_start. Expected:
  - stage_start pulses at 1, 7, 14; done at 22.
  - perf = 5, 6, 7 via perf_sel 0..2.
- Timeout: stage 1 never answers. Expected:
  - error=1, err_stage=1, busy=0 exactly 21 cycles after stage_start[1].
  - No stage_start[2]. clear_err → IDLE; the next start runs normally.
- Done/timeout collision: stage 0 answers exactly 20 cycles after start. Expected: no error, perf[0]=20, stage_start[1] next cycle.
- Spurious inputs:
  - stage_done[2] and start pulsed while stage 0 runs → ignored.
  - stage_active stays 3'b001.
  - perf[0] reflects only the real done.
- Reset mid-RUN during stage 1 → next cycle all outputs and perf registers are 0, state IDLE. A fresh start works.
- Back-to-back: start asserted in the cycle done is high → second run begins, stage_start[0] next cycle.
